// File: rtl/vram_arbiter_pkg.sv
// vram_pkg: owner/tag types and default widths shared by the VRAM arbiter slice.
package vram_pkg;
    localparam int VRAM_ADDR_W = 17;
    localparam int VRAM_DATA_W = 8;
    localparam int VRAM_RD_LAT = 3;
    typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_DRW} owner_e;
    typedef struct packed {
        owner_e owner;
        logic   is_read;
    } tag_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, draw-engine and RAM-side signals of the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int ADDR_W = vram_pkg::VRAM_ADDR_W,
    parameter int DATA_W = vram_pkg::VRAM_DATA_W
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              drw_valid;
    logic              drw_ready;
    logic              drw_we;
    logic [ADDR_W-1:0] drw_addr;
    logic [DATA_W-1:0] drw_wdata;
    logic [DATA_W-1:0] drw_rdata;
    logic              drw_rvalid;
    logic              drw_starve;
    logic              drw_starve_clr;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    modport slave (
        input  disp_req, disp_addr, drw_valid, drw_we, drw_addr, drw_wdata, drw_starve_clr, ram_rdata,
        output disp_data, disp_valid, drw_ready, drw_rdata, drw_rvalid, drw_starve,
        output ram_en, ram_we, ram_addr, ram_wdata
    );
    modport master (
        output disp_req, disp_addr, drw_valid, drw_we, drw_addr, drw_wdata, drw_starve_clr, ram_rdata,
        input  disp_data, disp_valid, drw_ready, drw_rdata, drw_rvalid, drw_starve,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter_return_pipe.sv
// vram_return_pipe: tracks each RAM access through the read latency and steers the
// returned word to the display or draw port.
module vram_return_pipe
    import vram_pkg::*;
#(
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  tag_t              tag,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [DATA_W-1:0] drw_rdata,
    output logic              drw_rvalid
);
    tag_t t0, t1;
    logic disp_hit, drw_hit;
    always_comb begin
        disp_hit = t1.owner == OWN_DISP && t1.is_read;
        drw_hit  = t1.owner == OWN_DRW && t1.is_read;
    end
    // t0 rides alongside the RAM strobe, t1 alongside the RAM read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            t0         <= '0;
            t1         <= '0;
            disp_valid <= 1'b0;
            drw_rvalid <= 1'b0;
            disp_data  <= '0;
            drw_rdata  <= '0;
        end else begin
            t0         <= tag;
            t1         <= t0;
            disp_valid <= disp_hit;
            drw_rvalid <= drw_hit;
            if (disp_hit) disp_data <= ram_rdata;
            if (drw_hit) drw_rdata <= ram_rdata;
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: fixed-priority sharing of one pixel RAM between VGA scanout and the
// drawing engine, with a sticky flag for a starved drawer.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int STARVE_LIM = 1024
) (
    input logic          clk,
    input logic          rst,
    vram_arbiter_if.slave bus
);
    logic              drw_win, stall;
    logic [ADDR_W-1:0] addr_sel;
    logic [15:0]       stall_cnt, stall_nxt;
    tag_t              tag;
    assign bus.drw_ready = !bus.disp_req;
    always_comb begin
        drw_win     = bus.drw_valid && !bus.disp_req;
        stall       = bus.drw_valid && bus.disp_req;
        addr_sel    = bus.disp_req ? bus.disp_addr : bus.drw_addr;
        tag.owner   = bus.disp_req ? OWN_DISP : drw_win ? OWN_DRW : OWN_NONE;
        tag.is_read = bus.disp_req || !bus.drw_we;
        stall_nxt   = (bus.drw_starve_clr || !stall) ? '0 : stall_cnt + 16'(stall_cnt != '1);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.ram_en     <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.drw_starve <= 1'b0;
            stall_cnt      <= '0;
        end else begin
            bus.ram_en     <= bus.disp_req || bus.drw_valid;
            bus.ram_we     <= drw_win && bus.drw_we;
            bus.ram_addr   <= addr_sel;
            bus.ram_wdata  <= bus.drw_wdata;
            stall_cnt      <= stall_nxt;
            bus.drw_starve <= !bus.drw_starve_clr && (bus.drw_starve || stall_nxt >= 16'(STARVE_LIM));
        end
    end
    vram_return_pipe #(.DATA_W(DATA_W)) u_ret (
        .clk       (clk),
        .rst       (rst),
        .tag       (tag),
        .ram_rdata (bus.ram_rdata),
        .disp_data (bus.disp_data),
        .disp_valid(bus.disp_valid),
        .drw_rdata (bus.drw_rdata),
        .drw_rvalid(bus.drw_rvalid)
    );
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector table plus corner sequences and mixed traffic against
// a reference memory; the RAM itself is modelled here with 1-cycle read latency.
module tb_vram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    vram_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus ();
    vram_arbiter #(.ADDR_W(17), .DATA_W(8), .STARVE_LIM(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    // unwritten words read back as their address low byte
    logic [7:0] mem [logic [16:0]];
    logic [7:0] ref_mem [logic [16:0]];
    always @(posedge clk)
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
            else bus.ram_rdata <= mem.exists(bus.ram_addr) ? mem[bus.ram_addr] : bus.ram_addr[7:0];
        end
    function automatic logic [7:0] rd_ref(input logic [16:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
    endfunction
    typedef struct {
        logic dreq; logic [16:0] daddr; logic dv; logic we; logic [16:0] waddr; logic [7:0] wd;
        logic e_rdy; logic e_dv; logic [7:0] e_dd; logic e_rv; logic [7:0] e_rd; logic e_we;
    } vec_t;
    typedef struct { int due; logic [7:0] d; } rsp_t;
    localparam logic O = 1'b0, I = 1'b1;
    localparam logic [16:0] AZ = 17'h0;
    localparam logic [7:0] DZ = 8'h0;
    vec_t tv [19];
    rsp_t dq [$], wq [$];
    int n_vec = 0, n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic drive(input logic dreq, input logic [16:0] daddr, input logic dv, input logic we,
                         input logic [16:0] waddr, input logic [7:0] wd, input logic clr);
        @(posedge clk);
        #1;
        bus.disp_req = dreq; bus.disp_addr = daddr; bus.drw_valid = dv; bus.drw_we = we;
        bus.drw_addr = waddr; bus.drw_wdata = wd; bus.drw_starve_clr = clr;
    endtask
    task automatic chk_reset(input string nm);
        chk({nm, " ram_en"}, 32'(bus.ram_en), 32'd0);
        chk({nm, " ram_we"}, 32'(bus.ram_we), 32'd0);
        chk({nm, " ram_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({nm, " ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
        chk({nm, " disp_valid"}, 32'(bus.disp_valid), 32'd0);
        chk({nm, " disp_data"}, 32'(bus.disp_data), 32'd0);
        chk({nm, " drw_rvalid"}, 32'(bus.drw_rvalid), 32'd0);
        chk({nm, " drw_rdata"}, 32'(bus.drw_rdata), 32'd0);
        chk({nm, " drw_starve"}, 32'(bus.drw_starve), 32'd0);
    endtask
    initial begin
        logic pend;
        logic ed, ew;
        logic [7:0] edd, ewd;
        tv[0]  = '{I, 17'h00010, O, O, AZ, DZ, O, O, DZ, O, DZ, O};
        tv[1]  = '{I, 17'h00011, O, O, AZ, DZ, O, O, DZ, O, DZ, O};
        tv[2]  = '{I, 17'h00012, O, O, AZ, DZ, O, O, DZ, O, DZ, O};
        tv[3]  = '{I, 17'h00013, O, O, AZ, DZ, O, I, 8'h10, O, DZ, O};
        tv[4]  = '{O, AZ, O, O, AZ, DZ, I, I, 8'h11, O, DZ, O};
        tv[5]  = '{O, AZ, O, O, AZ, DZ, I, I, 8'h12, O, DZ, O};
        tv[6]  = '{O, AZ, O, O, AZ, DZ, I, I, 8'h13, O, DZ, O};
        tv[7]  = '{O, AZ, I, I, 17'h12C00, 8'hA5, I, O, DZ, O, DZ, O};
        tv[8]  = '{O, AZ, I, O, 17'h12C00, DZ, I, O, DZ, O, DZ, I};
        tv[9]  = '{O, AZ, O, O, AZ, DZ, I, O, DZ, O, DZ, O};
        tv[10] = '{O, AZ, O, O, AZ, DZ, I, O, DZ, O, DZ, O};
        tv[11] = '{O, AZ, O, O, AZ, DZ, I, O, DZ, I, 8'hA5, O};
        tv[12] = '{I, 17'h00020, I, O, 17'h00005, DZ, O, O, DZ, O, DZ, O};
        tv[13] = '{I, 17'h00021, I, O, 17'h00005, DZ, O, O, DZ, O, DZ, O};
        tv[14] = '{O, AZ, I, O, 17'h00005, DZ, I, O, DZ, O, DZ, O};
        tv[15] = '{O, AZ, O, O, AZ, DZ, I, I, 8'h20, O, DZ, O};
        tv[16] = '{O, AZ, O, O, AZ, DZ, I, I, 8'h21, O, DZ, O};
        tv[17] = '{O, AZ, O, O, AZ, DZ, I, O, DZ, I, 8'h05, O};
        tv[18] = '{O, AZ, O, O, AZ, DZ, I, O, DZ, O, DZ, O};
        bus.disp_req = 0; bus.disp_addr = 0; bus.drw_valid = 0; bus.drw_we = 0;
        bus.drw_addr = 0; bus.drw_wdata = 0; bus.drw_starve_clr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 19; i++) begin
            drive(tv[i].dreq, tv[i].daddr, tv[i].dv, tv[i].we, tv[i].waddr, tv[i].wd, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d drw_ready", i), 32'(bus.drw_ready), 32'(tv[i].e_rdy));
            chk($sformatf("v%0d disp_valid", i), 32'(bus.disp_valid), 32'(tv[i].e_dv));
            if (tv[i].e_dv) chk($sformatf("v%0d disp_data", i), 32'(bus.disp_data), 32'(tv[i].e_dd));
            chk($sformatf("v%0d drw_rvalid", i), 32'(bus.drw_rvalid), 32'(tv[i].e_rv));
            if (tv[i].e_rv) chk($sformatf("v%0d drw_rdata", i), 32'(bus.drw_rdata), 32'(tv[i].e_rd));
            chk($sformatf("v%0d ram_we", i), 32'(bus.ram_we), 32'(tv[i].e_we));
        end
        // stall for 10 cycles, clear at cycle 10 while still stalled, flag re-sets 8 cycles on
        for (int k = 0; k < 21; k++) begin
            drive(1'b1, 17'h00001, 1'b1, 1'b0, 17'h00002, DZ, k == 10);
            @(negedge clk);
            chk($sformatf("starve c%0d", k), 32'(bus.drw_starve), 32'((k >= 8 && k <= 10) || k >= 19));
        end
        drive(1'b0, AZ, 1'b0, 1'b0, AZ, DZ, 1'b0);
        @(negedge clk);
        chk("starve sticky", 32'(bus.drw_starve), 32'd1);
        drive(1'b1, 17'h00030, 1'b0, 1'b0, AZ, DZ, 1'b0);
        drive(1'b1, 17'h00031, 1'b1, 1'b1, 17'h00007, 8'h77, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst drw_ready", 32'(bus.drw_ready), 32'd0);
        drive(1'b0, AZ, 1'b0, 1'b0, AZ, DZ, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, AZ, 1'b0, 1'b0, AZ, DZ, 1'b0);
            @(negedge clk);
            chk("midrst no disp_valid", 32'(bus.disp_valid), 32'd0);
            chk("midrst no ram_we", 32'(bus.ram_we), 32'd0);
        end
        pend = 1'b0;
        for (int k = 0; k < 10004; k++) begin
            @(posedge clk);
            #1;
            bus.disp_req = k < 10000 && k % 2 == 0;
            bus.disp_addr = 17'($urandom_range(0, 15));
            if (!pend && k < 10000) begin
                pend = $urandom_range(0, 3) != 0;
                bus.drw_we = 1'($urandom_range(0, 1));
                bus.drw_addr = 17'($urandom_range(0, 15));
                bus.drw_wdata = 8'($urandom);
            end
            bus.drw_valid = pend;
            if (bus.disp_req) dq.push_back('{k + 3, rd_ref(bus.disp_addr)});
            else if (pend) begin
                if (bus.drw_we) ref_mem[bus.drw_addr] = bus.drw_wdata;
                else wq.push_back('{k + 3, rd_ref(bus.drw_addr)});
                pend = 1'b0;
            end
            @(negedge clk);
            ed = dq.size() != 0 && dq[0].due == k;
            ew = wq.size() != 0 && wq[0].due == k;
            edd = ed ? dq[0].d : DZ;
            ewd = ew ? wq[0].d : DZ;
            if (ed) void'(dq.pop_front());
            if (ew) void'(wq.pop_front());
            chk($sformatf("rnd c%0d disp_valid", k), 32'(bus.disp_valid), 32'(ed));
            if (ed) chk($sformatf("rnd c%0d disp_data", k), 32'(bus.disp_data), 32'(edd));
            chk($sformatf("rnd c%0d drw_rvalid", k), 32'(bus.drw_rvalid), 32'(ew));
            if (ew) chk($sformatf("rnd c%0d drw_rdata", k), 32'(bus.drw_rdata), 32'(ewd));
            chk($sformatf("rnd c%0d both_valid", k), 32'(bus.disp_valid & bus.drw_rvalid), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
